// File: rtl/memn2n_fifo_feeder_if.sv
// Handshake bundle between the host input FIFO / command side and the MemN2N feeder.
// The feeder sits on the slave modport; whoever drives commands and the FIFO uses master.
interface memn2n_fifo_feeder_if #(
    parameter int BW_DATA_IN = 32,
    parameter int BW_NUM     = 8
) ();

    logic                  start;
    logic [BW_NUM-1:0]     num_words;
    logic                  fifo_empty;
    logic [BW_DATA_IN-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [BW_DATA_IN-1:0] data_out;
    logic                  en;
    logic                  en_init;
    logic                  busy;
    logic                  done;
    logic [BW_NUM-1:0]     word_cnt;

    modport master (
        output start,
        output num_words,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  data_out,
        input  en,
        input  en_init,
        input  busy,
        input  done,
        input  word_cnt
    );

    modport slave (
        input  start,
        input  num_words,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output data_out,
        output en,
        output en_init,
        output busy,
        output done,
        output word_cnt
    );

endinterface

// File: rtl/memn2n_fifo_feeder.sv
// Pulls story words out of the host input FIFO and sequences en_init/en for the MemN2N core,
// one fixed-length enable window per word, with the final (answer) word getting a short window.
module memn2n_fifo_feeder #(
    parameter int BW_DATA_IN        = 32,
    parameter int BW_CNT            = 16,
    parameter int INIT_PULSE_CYCLES = 1,
    parameter int INIT_WAIT_CYCLES  = 60,
    parameter int RUN_CYCLES        = 40,
    parameter int LAST_RUN_CYCLES   = 1,
    parameter int BW_NUM            = 8
) (
    input  logic                clk,
    input  logic                rst,
    memn2n_fifo_feeder_if.slave bus
);

    // A zero-length window would never terminate the counter compare, so it is clamped to one.
    localparam int INIT_LEN     = (INIT_PULSE_CYCLES < 1) ? 1 : INIT_PULSE_CYCLES;
    localparam int WAIT_LEN     = (INIT_WAIT_CYCLES  < 1) ? 1 : INIT_WAIT_CYCLES;
    localparam int RUN_LEN      = (RUN_CYCLES        < 1) ? 1 : RUN_CYCLES;
    localparam int LAST_RUN_LEN = (LAST_RUN_CYCLES   < 1) ? 1 : LAST_RUN_CYCLES;

    localparam logic [BW_CNT-1:0] INIT_END     = BW_CNT'(INIT_LEN - 1);
    localparam logic [BW_CNT-1:0] WAIT_END     = BW_CNT'(WAIT_LEN - 1);
    localparam logic [BW_CNT-1:0] RUN_END      = BW_CNT'(RUN_LEN - 1);
    localparam logic [BW_CNT-1:0] LAST_RUN_END = BW_CNT'(LAST_RUN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        INIT_WAIT,
        POP,
        LATCH,
        RUN,
        GAP,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [BW_CNT-1:0]     cnt;
    logic [BW_NUM-1:0]     num_latched;
    logic [BW_NUM-1:0]     word_cnt_q;
    logic [BW_DATA_IN-1:0] data_q;
    logic                  last_word;
    logic [BW_CNT-1:0]     run_end;
    logic                  accept;

    logic fifo_rd_en_c;
    logic en_c;
    logic en_init_c;
    logic busy_c;
    logic done_c;

    // word_cnt is bumped in LATCH, so during RUN it already counts the word being presented.
    assign last_word = (word_cnt_q == num_latched);
    assign run_end   = last_word ? LAST_RUN_END : RUN_END;
    assign accept    = (state == IDLE) && bus.start && (bus.num_words != '0);

    always_comb begin
        next_state   = state;
        fifo_rd_en_c = 1'b0;
        en_c         = 1'b0;
        en_init_c    = 1'b0;
        busy_c       = (state != IDLE);
        done_c       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.num_words == '0) ? DONE : INIT;
                end
            end
            INIT: begin
                en_init_c = 1'b1;
                if (cnt == INIT_END) begin
                    next_state = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (cnt == WAIT_END) begin
                    next_state = POP;
                end
            end
            POP: begin
                if (!bus.fifo_empty) begin
                    fifo_rd_en_c = 1'b1;
                    next_state   = LATCH;
                end
            end
            LATCH: begin
                next_state = RUN;
            end
            RUN: begin
                en_c = 1'b1;
                if (cnt == run_end) begin
                    next_state = last_word ? DONE : GAP;
                end
            end
            GAP: begin
                next_state = POP;
            end
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The cycle counter restarts on every state change, so each state times itself from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // fifo_dout is valid in LATCH (one cycle after the pop), and data_out only ever moves there.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_latched <= '0;
            word_cnt_q  <= '0;
            data_q      <= '0;
        end else begin
            if (accept) begin
                num_latched <= bus.num_words;
                word_cnt_q  <= '0;
            end
            if (state == LATCH) begin
                data_q     <= bus.fifo_dout;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = fifo_rd_en_c;
    assign bus.en         = en_c;
    assign bus.en_init    = en_init_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.data_out   = data_q;
    assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_memn2n_fifo_feeder.sv
// Directed bench for memn2n_fifo_feeder: a behavioural FIFO feeds the DUT and each run is
// traced cycle by cycle from the start pulse, then compared against hand-derived timings.
module tb_memn2n_fifo_feeder;

    logic clk = 1'b0;
    logic rst;

    int assert_count = 0;
    int fail_count   = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_words[8];

    int init_cycles;
    int rd_count;
    int rd_while_empty;
    int windows;
    int win_len[8];
    int data_errs;
    int done_count;
    int done_at;
    int first_rd;
    int first_en;
    int wc_at_done;
    logic busy_after_done;
    logic finished;

    always #5 clk = ~clk;

    memn2n_fifo_feeder_if #(.BW_DATA_IN(32), .BW_NUM(8)) bus ();

    memn2n_fifo_feeder #(
        .BW_DATA_IN(32),
        .BW_CNT(16),
        .INIT_PULSE_CYCLES(1),
        .INIT_WAIT_CYCLES(60),
        .RUN_CYCLES(40),
        .LAST_RUN_CYCLES(1),
        .BW_NUM(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Standard-mode FIFO: data appears the cycle after the pop, empty flag is registered.
    always @(posedge clk) begin
        if (bus.fifo_rd_en && fifo_q.size() != 0) begin
            bus.fifo_dout <= fifo_q.pop_front();
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pulses start with num and traces the run; sample k is taken in the k-th cycle after start.
    task automatic applyStimulus(input logic [7:0] num, input int max_cycles, input int restart_at,
                                 input int reset_at, input int push_at, input logic [31:0] push_data);
        logic prev_en;
        int   cur_len;
        logic done_prev;
        init_cycles     = 0;
        rd_count        = 0;
        rd_while_empty  = 0;
        windows         = 0;
        data_errs       = 0;
        done_count      = 0;
        done_at         = -1;
        first_rd        = -1;
        first_en        = -1;
        wc_at_done      = -1;
        busy_after_done = 1'b1;
        finished        = 1'b0;
        for (int i = 0; i < 8; i++) win_len[i] = 0;
        prev_en   = 1'b0;
        cur_len   = 0;
        done_prev = 1'b0;
        bus.start     = 1'b1;
        bus.num_words = num;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (k == restart_at) bus.num_words = 8'd7;
            rst = (k == reset_at);
            if (k == push_at) fifo_q.push_back(push_data);
            if (reset_at > 0 && k == reset_at + 1) begin
                finished = 1'b1;
                break;
            end
            if (done_prev) begin
                busy_after_done = bus.busy;
                finished        = 1'b1;
                break;
            end
            if (bus.en_init) init_cycles++;
            if (bus.fifo_rd_en) begin
                rd_count++;
                if (first_rd < 0) first_rd = k;
                if (bus.fifo_empty) rd_while_empty++;
            end
            if (bus.en) begin
                if (!prev_en) begin
                    windows++;
                    cur_len = 0;
                    if (first_en < 0) first_en = k;
                end
                cur_len++;
                if (windows > 8 || bus.data_out !== exp_words[windows-1]) data_errs++;
            end else if (prev_en && windows <= 8) begin
                win_len[windows-1] = cur_len;
            end
            prev_en = bus.en;
            if (bus.done) begin
                done_count++;
                done_at    = k;
                wc_at_done = int'(bus.word_cnt);
            end
            done_prev = bus.done;
        end
        if (prev_en && windows > 0 && windows <= 8) win_len[windows-1] = cur_len;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_words = 8'd0;
        fifo_q.push_back(32'h008000fc);
        fifo_q.push_back(32'h00010203);
        fifo_q.push_back(32'h11111111);
        fifo_q.push_back(32'h0000002a);
        repeat (3) @(negedge clk);
        checkOutput("reset_en",       32'(bus.en),         32'd0);
        checkOutput("reset_en_init",  32'(bus.en_init),    32'd0);
        checkOutput("reset_rd_en",    32'(bus.fifo_rd_en), 32'd0);
        checkOutput("reset_busy",     32'(bus.busy),       32'd0);
        checkOutput("reset_done",     32'(bus.done),       32'd0);
        checkOutput("reset_data_out", bus.data_out,        32'd0);
        checkOutput("reset_word_cnt", 32'(bus.word_cnt),   32'd0);
        rst = 1'b0;

        $display("[TB] four-word story");
        exp_words[0] = 32'h008000fc;
        exp_words[1] = 32'h00010203;
        exp_words[2] = 32'h11111111;
        exp_words[3] = 32'h0000002a;
        applyStimulus(8'd4, 400, 0, 0, 0, 32'h0);
        checkOutput("run4_finished",    32'(finished),        32'd1);
        checkOutput("run4_init_cycles", 32'(init_cycles),     32'd1);
        checkOutput("run4_first_rd",    32'(first_rd),        32'd62);
        checkOutput("run4_rd_count",    32'(rd_count),        32'd4);
        checkOutput("run4_windows",     32'(windows),         32'd4);
        checkOutput("run4_len0",        32'(win_len[0]),      32'd40);
        checkOutput("run4_len1",        32'(win_len[1]),      32'd40);
        checkOutput("run4_len2",        32'(win_len[2]),      32'd40);
        checkOutput("run4_len3",        32'(win_len[3]),      32'd1);
        checkOutput("run4_first_en",    32'(first_en),        32'd64);
        checkOutput("run4_data_errs",   32'(data_errs),       32'd0);
        checkOutput("run4_done_count",  32'(done_count),      32'd1);
        checkOutput("run4_done_at",     32'(done_at),         32'd194);
        checkOutput("run4_word_cnt",    32'(wc_at_done),      32'd4);
        checkOutput("run4_busy_after",  32'(busy_after_done), 32'd0);
        checkOutput("run4_data_hold",   bus.data_out,         32'h0000002a);

        $display("[TB] empty FIFO stall");
        exp_words[0] = 32'hdeadbeef;
        applyStimulus(8'd1, 300, 0, 0, 86, 32'hdeadbeef);
        checkOutput("stall_finished",   32'(finished),       32'd1);
        checkOutput("stall_rd_empty",   32'(rd_while_empty), 32'd0);
        checkOutput("stall_first_rd",   32'(first_rd),       32'd87);
        checkOutput("stall_rd_count",   32'(rd_count),       32'd1);
        checkOutput("stall_first_en",   32'(first_en),       32'd89);
        checkOutput("stall_data_errs",  32'(data_errs),      32'd0);
        checkOutput("stall_done_at",    32'(done_at),        32'd90);

        $display("[TB] zero-length run");
        applyStimulus(8'd0, 20, 0, 0, 0, 32'h0);
        checkOutput("zero_done_at",     32'(done_at),         32'd1);
        checkOutput("zero_done_count",  32'(done_count),      32'd1);
        checkOutput("zero_init_cycles", 32'(init_cycles),     32'd0);
        checkOutput("zero_rd_count",    32'(rd_count),        32'd0);
        checkOutput("zero_windows",     32'(windows),         32'd0);
        checkOutput("zero_busy_after",  32'(busy_after_done), 32'd0);

        $display("[TB] start re-pulsed during RUN");
        fifo_q.push_back(32'h01234567);
        fifo_q.push_back(32'h89abcdef);
        exp_words[0] = 32'h01234567;
        exp_words[1] = 32'h89abcdef;
        applyStimulus(8'd2, 400, 70, 0, 0, 32'h0);
        checkOutput("restart_rd_count",  32'(rd_count),    32'd2);
        checkOutput("restart_windows",   32'(windows),     32'd2);
        checkOutput("restart_len0",      32'(win_len[0]),  32'd40);
        checkOutput("restart_len1",      32'(win_len[1]),  32'd1);
        checkOutput("restart_done_at",   32'(done_at),     32'd108);
        checkOutput("restart_word_cnt",  32'(wc_at_done),  32'd2);
        checkOutput("restart_data_errs", 32'(data_errs),   32'd0);

        $display("[TB] reset mid-RUN");
        fifo_q.push_back(32'haaaa5555);
        fifo_q.push_back(32'h5555aaaa);
        fifo_q.push_back(32'h13572468);
        exp_words[0] = 32'haaaa5555;
        applyStimulus(8'd2, 400, 0, 80, 0, 32'h0);
        checkOutput("rstrun_rd_count", 32'(rd_count),     32'd1);
        checkOutput("rstrun_en",       32'(bus.en),       32'd0);
        checkOutput("rstrun_busy",     32'(bus.busy),     32'd0);
        checkOutput("rstrun_data_out", bus.data_out,      32'd0);
        checkOutput("rstrun_word_cnt", 32'(bus.word_cnt), 32'd0);

        exp_words[0] = 32'h5555aaaa;
        applyStimulus(8'd1, 200, 0, 0, 0, 32'h0);
        checkOutput("after_rst_init",     32'(init_cycles), 32'd1);
        checkOutput("after_rst_first_rd", 32'(first_rd),    32'd62);
        checkOutput("after_rst_done_at",  32'(done_at),     32'd65);
        checkOutput("after_rst_data",     32'(data_errs),   32'd0);

        $display("[TB] back-to-back start");
        exp_words[0] = 32'h13572468;
        applyStimulus(8'd1, 200, 0, 0, 0, 32'h0);
        checkOutput("b2b_init_cycles", 32'(init_cycles), 32'd1);
        checkOutput("b2b_first_rd",    32'(first_rd),    32'd62);
        checkOutput("b2b_done_at",     32'(done_at),     32'd65);
        checkOutput("b2b_data_errs",   32'(data_errs),   32'd0);
        checkOutput("b2b_word_cnt",    32'(wc_at_done),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
